// File: rtl/godai_trace_buffer.sv
// Trace capture FIFO for the Godai core: time-stamps masked event strobes and drains records over valid/ready.
// Define TRACE_DEDUP_EN to suppress hits identical (events, instr_count) to the last pushed record.
module godai_trace_buffer #(
    parameter  int NUM_EVENTS = 6,
    parameter  int DEPTH      = 16,
    parameter  int TS_WIDTH   = 16,
    localparam int REC_WIDTH  = TS_WIDTH + NUM_EVENTS + 32,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_mask_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic [31:0]           instr_count_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [REC_WIDTH-1:0]  rec_data_o,
    output logic [LVL_W-1:0]      level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_count_o
);

    logic [REC_WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_q, drop_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;

    logic [NUM_EVENTS-1:0] ev_masked;
    logic                  hit, pop, dup, push, drop;

    always_comb begin
        ev_masked = events_i & event_mask_i;
        hit       = enable_i & (|ev_masked);
        pop       = ~empty_q & rec_ready_i;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the hit.
        push      = hit & ~dup & (~full_q | pop);
        drop      = hit & ~dup & full_q & ~pop;
    end

`ifdef TRACE_DEDUP_EN
    logic                  last_valid_q;
    logic [NUM_EVENTS-1:0] last_ev_q;
    logic [31:0]           last_ic_q;

    assign dup = last_valid_q && (last_ev_q == ev_masked) && (last_ic_q == instr_count_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_valid_q <= 1'b0;
            last_ev_q    <= '0;
            last_ic_q    <= '0;
        end else if (clear_i) begin
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_valid_q <= 1'b1;
            last_ev_q    <= ev_masked;
            last_ic_q    <= instr_count_i;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        ts_d       = ts_q + TS_WIDTH'(1);
        // Clear treats the current cycle as ts=0, so the following cycle reads ts=1.
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            ts_d       = TS_WIDTH'(1);
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            ts_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            ts_q       <= ts_d;
        end
    end

    // NOTE: the record array has no reset; contents are only visible through rec_data_o when non-empty.
    always_ff @(posedge clk) begin
        if (push && !clear_i) mem_q[wr_ptr_q] <= {ts_q, ev_masked, instr_count_i};
    end

    assign rec_valid_o  = ~empty_q;
    assign rec_data_o   = empty_q ? '0 : mem_q[rd_ptr_q];
    assign level_o      = level_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule
